// File: rtl/sram_bist_ctrl_if.sv
// Pin bundle between the BIST sequencer and the 16x8 single-port SRAM wrapper.
// The master side drives the access pins; the slave (RAM) returns dout.
interface sram_bist_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();
  logic              mem_ce;
  logic              mem_oce;
  logic              mem_reset;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output mem_ce, mem_oce, mem_reset, mem_wre, mem_ad, mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_ce, mem_oce, mem_reset, mem_wre, mem_ad, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// Three-pass march BIST (fill, read-modify-write invert, verify) for a
// read-before-write, bypass-read SRAM, with first-failure capture.
module sram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = 'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got,
  output logic [1:0]        err_phase,
  sram_bist_ctrl_if.master  mem
);

  typedef enum logic [2:0] {IDLE, FILL, MARCH, VERIFY, DRAIN} state_t;

  localparam logic [1:0] PH_MARCH  = 2'd1;
  localparam logic [1:0] PH_VERIFY = 2'd2;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return SEED ^ DATA_W'(a);
  endfunction

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;

  logic              chk_valid, chk_valid_nx;
  logic [DATA_W-1:0] chk_exp, chk_exp_nx;
  logic [ADDR_W-1:0] chk_addr, chk_addr_nx;
  logic [1:0]        chk_phase, chk_phase_nx;

  logic              busy_nx, done_nx, pass_nx;
  logic [7:0]        err_cnt_nx;
  logic [ADDR_W-1:0] err_addr_nx;
  logic [DATA_W-1:0] err_exp_nx, err_got_nx;
  logic [1:0]        err_phase_nx;

  logic              ce_nx, wre_nx;
  logic [ADDR_W-1:0] ad_nx;
  logic [DATA_W-1:0] din_nx;

  logic              issue;
  state_t            issue_state;
  logic [ADDR_W-1:0] issue_addr;

  // The state names the access presented in the current cycle; each edge
  // captures that access into the check stage and sets up the next one.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    chk_valid_nx = 1'b0;
    chk_exp_nx   = chk_exp;
    chk_addr_nx  = chk_addr;
    chk_phase_nx = chk_phase;
    busy_nx      = busy;
    done_nx      = 1'b0;
    pass_nx      = pass;
    err_cnt_nx   = err_cnt;
    err_addr_nx  = err_addr;
    err_exp_nx   = err_exp;
    err_got_nx   = err_got;
    err_phase_nx = err_phase;
    ce_nx        = 1'b0;
    wre_nx       = 1'b0;
    ad_nx        = mem.mem_ad;
    din_nx       = mem.mem_din;
    issue        = 1'b0;
    issue_state  = state;
    issue_addr   = addr;

    if (chk_valid && (mem.mem_dout != chk_exp)) begin
      if (err_cnt != 8'hFF) err_cnt_nx = err_cnt + 8'd1;
      if (err_cnt == 8'd0) begin
        err_addr_nx  = chk_addr;
        err_exp_nx   = chk_exp;
        err_got_nx   = mem.mem_dout;
        err_phase_nx = chk_phase;
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nx     = FILL;
          addr_nx      = '0;
          busy_nx      = 1'b1;
          pass_nx      = 1'b0;
          err_cnt_nx   = '0;
          err_addr_nx  = '0;
          err_exp_nx   = '0;
          err_got_nx   = '0;
          err_phase_nx = '0;
          issue        = 1'b1;
          issue_state  = FILL;
          issue_addr   = '0;
        end
      end
      FILL, MARCH, VERIFY: begin
        chk_valid_nx = (state != FILL);
        chk_exp_nx   = (state == MARCH) ? pat(addr) : ~pat(addr);
        chk_addr_nx  = addr;
        chk_phase_nx = (state == MARCH) ? PH_MARCH : PH_VERIFY;
        addr_nx      = addr + 1'b1;
        issue_addr   = addr + 1'b1;
        if (addr == '1) begin
          case (state)
            FILL:    state_nx = MARCH;
            MARCH:   state_nx = VERIFY;
            default: state_nx = DRAIN;
          endcase
        end
        issue       = (state_nx != DRAIN);
        issue_state = state_nx;
      end
      DRAIN: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        pass_nx  = (err_cnt_nx == 8'd0);
      end
      default: state_nx = IDLE;
    endcase

    if (issue) begin
      ce_nx  = 1'b1;
      ad_nx  = issue_addr;
      wre_nx = (issue_state != VERIFY);
      if (issue_state == FILL)       din_nx = pat(issue_addr);
      else if (issue_state == MARCH) din_nx = ~pat(issue_addr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      addr          <= '0;
      chk_valid     <= 1'b0;
      chk_exp       <= '0;
      chk_addr      <= '0;
      chk_phase     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      err_addr      <= '0;
      err_exp       <= '0;
      err_got       <= '0;
      err_phase     <= '0;
      mem.mem_ce    <= 1'b0;
      mem.mem_oce   <= 1'b1;
      mem.mem_reset <= 1'b0;
      mem.mem_wre   <= 1'b0;
      mem.mem_ad    <= '0;
      mem.mem_din   <= '0;
    end else begin
      state         <= state_nx;
      addr          <= addr_nx;
      chk_valid     <= chk_valid_nx;
      chk_exp       <= chk_exp_nx;
      chk_addr      <= chk_addr_nx;
      chk_phase     <= chk_phase_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      pass          <= pass_nx;
      err_cnt       <= err_cnt_nx;
      err_addr      <= err_addr_nx;
      err_exp       <= err_exp_nx;
      err_got       <= err_got_nx;
      err_phase     <= err_phase_nx;
      mem.mem_ce    <= ce_nx;
      mem.mem_oce   <= 1'b1;
      mem.mem_reset <= 1'b0;
      mem.mem_wre   <= wre_nx;
      mem.mem_ad    <= ad_nx;
      mem.mem_din   <= din_nx;
    end
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl with a behavioural read-before-write
// SRAM that can model stuck-at cells.
module tb_sram_bist_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, pass;
  logic [7:0]        err_cnt;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] err_exp, err_got;
  logic [1:0]        err_phase;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [7:0] ram      [DEPTH];
  logic [7:0] fault_or [DEPTH];
  logic [7:0] fault_and;

  sram_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  sram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(8'hA5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .err_addr  (err_addr),
    .err_exp   (err_exp),
    .err_got   (err_got),
    .err_phase (err_phase),
    .mem       (mem_bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-before-write RAM: dout returns the old word; stuck bits bend writes.
  always @(posedge clk) begin
    if (mem_bus.mem_reset) mem_bus.mem_dout <= '0;
    else if (mem_bus.mem_ce) begin
      mem_bus.mem_dout <= ram[mem_bus.mem_ad];
      if (mem_bus.mem_wre)
        ram[mem_bus.mem_ad] <= (mem_bus.mem_din | fault_or[mem_bus.mem_ad]) & fault_and;
    end
  end

  task automatic set_no_fault();
    for (int i = 0; i < DEPTH; i++) fault_or[i] = 8'h00;
    fault_and = 8'hFF;
  endtask

  task automatic do_run(output int lat);
    int c0;
    lat = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, mem_bus.mem_ce, mem_bus.mem_oce} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL reset_held busy/ce/oce got=%b exp=001", {busy, mem_bus.mem_ce, mem_bus.mem_oce});
    end
    @(posedge clk); #3 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_busy cycle %0d got=%b exp=0", i, busy);
      end
      tests_run++;
      if (mem_bus.mem_ce !== 1'b0 || mem_bus.mem_wre !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_ce_wre cycle %0d got=%b%b exp=00", i, mem_bus.mem_ce, mem_bus.mem_wre);
      end
      tests_run++;
      if (mem_bus.mem_oce !== 1'b1 || mem_bus.mem_reset !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_oce_reset cycle %0d got=%b%b exp=10", i, mem_bus.mem_oce, mem_bus.mem_reset);
      end
      tests_run++;
      if ({err_cnt, err_addr, err_exp, err_got, err_phase, done, pass} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL idle_err cycle %0d cnt=%h addr=%h exp=%h got=%h ph=%0d done=%b pass=%b exp=all 0",
                 i, err_cnt, err_addr, err_exp, err_got, err_phase, done, pass);
      end
    end
  endtask

  task automatic test_fault_free();
    int lat;
    logic [7:0] exp_word;
    set_no_fault();
    do_run(lat);
    tests_run++;
    if (lat != 49) begin
      tests_failed++;
      $display("[TB] FAIL ff_latency got=%0d exp=49", lat);
    end
    tests_run++;
    if (pass !== 1'b1 || err_cnt !== 8'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ff_result pass=%b cnt=%0d busy=%b exp pass=1 cnt=0 busy=0", pass, err_cnt, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ff_done_pulse got=%b exp=0", done);
    end
    tests_run++;
    if (ram[3] !== 8'h59) begin
      tests_failed++;
      $display("[TB] FAIL ff_ram3 got=%h exp=59", ram[3]);
    end
    for (int a = 0; a < DEPTH; a++) begin
      exp_word = ~(8'hA5 ^ 8'(a));
      tests_run++;
      if (ram[a] !== exp_word) begin
        tests_failed++;
        $display("[TB] FAIL ff_ram addr %0d got=%h exp=%h", a, ram[a], exp_word);
      end
    end
  endtask

  task automatic test_march_fault();
    int lat;
    set_no_fault();
    fault_or[5] = 8'h01;
    do_run(lat);
    tests_run++;
    if (lat != 49 || pass !== 1'b0 || err_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL mf_result lat=%0d pass=%b cnt=%0d exp lat=49 pass=0 cnt=1", lat, pass, err_cnt);
    end
    tests_run++;
    if (err_addr !== 4'd5 || err_phase !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL mf_where addr=%0d ph=%0d exp addr=5 ph=1", err_addr, err_phase);
    end
    tests_run++;
    if (err_exp !== 8'hA0 || err_got !== 8'hA1) begin
      tests_failed++;
      $display("[TB] FAIL mf_data exp=%h got=%h required exp=A0 got=A1", err_exp, err_got);
    end
  endtask

  task automatic test_stuck_bit7();
    int lat;
    set_no_fault();
    fault_and = 8'h7F;
    do_run(lat);
    tests_run++;
    if (lat != 49 || pass !== 1'b0 || err_cnt !== 8'd16) begin
      tests_failed++;
      $display("[TB] FAIL s7_result lat=%0d pass=%b cnt=%0d exp lat=49 pass=0 cnt=16", lat, pass, err_cnt);
    end
    tests_run++;
    if (err_addr !== 4'd0 || err_phase !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL s7_where addr=%0d ph=%0d exp addr=0 ph=1", err_addr, err_phase);
    end
    tests_run++;
    if (err_exp !== 8'hA5 || err_got !== 8'h25) begin
      tests_failed++;
      $display("[TB] FAIL s7_data exp=%h got=%h required exp=A5 got=25", err_exp, err_got);
    end
  endtask

  // Bit 0 of pat(4)=A1 is already 1, so only the inverted word 5E is disturbed.
  task automatic test_verify_fault();
    int lat;
    set_no_fault();
    fault_or[4] = 8'h01;
    do_run(lat);
    tests_run++;
    if (lat != 49 || pass !== 1'b0 || err_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL vf_result lat=%0d pass=%b cnt=%0d exp lat=49 pass=0 cnt=1", lat, pass, err_cnt);
    end
    tests_run++;
    if (err_addr !== 4'd4 || err_phase !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL vf_where addr=%0d ph=%0d exp addr=4 ph=2", err_addr, err_phase);
    end
    tests_run++;
    if (err_exp !== 8'h5E || err_got !== 8'h5F) begin
      tests_failed++;
      $display("[TB] FAIL vf_data exp=%h got=%h required exp=5E got=5F", err_exp, err_got);
    end
  endtask

  task automatic test_start_while_busy();
    int c0, ndone, first;
    logic pass_at, busy_at;
    logic [7:0] cnt_at;
    logic [ADDR_W-1:0] addr_at;
    set_no_fault();
    ndone = 0; first = -1; pass_at = 1'b0; cnt_at = 8'hXX; addr_at = 'x;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    busy_at = busy;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = cyc - c0;
          pass_at = pass;
          cnt_at = err_cnt;
          addr_at = err_addr;
        end
      end
    end
    tests_run++;
    if (busy_at !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL swb_busy got=%b exp=1", busy_at);
    end
    tests_run++;
    if (ndone != 1 || first != 49) begin
      tests_failed++;
      $display("[TB] FAIL swb_done count=%0d at=%0d exp count=1 at=49", ndone, first);
    end
    tests_run++;
    if (pass_at !== 1'b1 || cnt_at !== 8'd0 || addr_at !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL swb_result pass=%b cnt=%0d addr=%0d exp pass=1 cnt=0 addr=0", pass_at, cnt_at, addr_at);
    end
  endtask

  task automatic test_reset_midrun();
    int c0, ndone, lat;
    set_no_fault();
    fault_or[5] = 8'h01;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
    repeat (24) @(posedge clk);
    #3;
    tests_run++;
    if (busy !== 1'b1 || err_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL mr_before busy=%b cnt=%0d exp busy=1 cnt=1", busy, err_cnt);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, mem_bus.mem_ce, mem_bus.mem_wre, mem_bus.mem_oce} !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL mr_async busy/done/ce/wre/oce got=%b exp=00001",
               {busy, done, mem_bus.mem_ce, mem_bus.mem_wre, mem_bus.mem_oce});
    end
    tests_run++;
    if ({err_cnt, err_addr, err_exp, err_got, err_phase, mem_bus.mem_ad, mem_bus.mem_din} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mr_async_err cnt=%h addr=%h exp=%h got=%h ph=%0d ad=%h din=%h exp=all 0",
               err_cnt, err_addr, err_exp, err_got, err_phase, mem_bus.mem_ad, mem_bus.mem_din);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    tests_run++;
    if (ndone != 0) begin
      tests_failed++;
      $display("[TB] FAIL mr_no_done count=%0d exp=0", ndone);
    end
    set_no_fault();
    do_run(lat);
    tests_run++;
    if (lat != 49 || pass !== 1'b1 || err_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL mr_rerun lat=%0d pass=%b cnt=%0d exp lat=49 pass=1 cnt=0", lat, pass, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int c0, ndone;
    int d [3];
    logic after_done;
    set_no_fault();
    ndone = 0; after_done = 1'b0;
    for (int k = 0; k < 3; k++) d[k] = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (after_done) begin
        tests_run++;
        if (busy !== 1'b1 || pass !== 1'b0 || done !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_restart busy=%b pass=%b done=%b exp busy=1 pass=0 done=0", busy, pass, done);
        end
      end
      after_done = done;
      if (done) begin
        if (ndone < 3) d[ndone] = cyc - c0;
        ndone++;
        tests_run++;
        if (pass !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b_pass got=%b exp=1", pass);
        end
      end
    end
    tests_run++;
    if (ndone != 3 || d[0] != 49 || d[1] != 99 || d[2] != 149) begin
      tests_failed++;
      $display("[TB] FAIL b2b_spacing count=%0d at=%0d,%0d,%0d exp count=3 at=49,99,149", ndone, d[0], d[1], d[2]);
    end
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);
  endtask

  initial begin
    set_no_fault();
    test_reset();
    test_fault_free();
    test_march_fault();
    test_stuck_bit7();
    test_verify_fault();
    test_start_while_busy();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- Built-in self-test sequencer for the 16x8 single-port block SRAM wrapper.
- Drives the wrapper's ce/oce/reset/wre/ad/din pins and checks its dout.
- The RAM is configured for bypass read (dout valid the cycle after the access edge) and read-before-write (a write returns the old word on dout).
- Runs a three-pass march (fill, read-modify-write invert, verify), then reports pass/fail, first failure details and an error count.

Parameters:
ADDR_W, 4, RAM address width; depth = 2^ADDR_W
DATA_W, 8, RAM data width
SEED, 8'hA5, base pattern; pat(a) = SEED ^ a, with a zero-extended to DATA_W

Ports:
clk  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  level-sampled; begins a run when idle
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when a run completes
pass  out  1  result of last run, valid from done, held until next start
err_cnt  out  8  mismatches in last run, saturates at 255
err_addr  out  ADDR_W  address of first mismatch
err_exp  out  DATA_W  expected word at first mismatch
err_got  out  DATA_W  observed word at first mismatch
err_phase  out  2  pass of first mismatch: 1=MARCH, 2=VERIFY
mem_ce  out  1  RAM clock enable
mem_oce  out  1  RAM output clock enable, constant 1 after reset
mem_reset  out  1  RAM output reset, constant 0
mem_wre  out  1  RAM write enable
mem_ad  out  ADDR_W  RAM address
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data

Behaviour:
- Reset (async, reset_n=0) sets state IDLE.
  - busy, done, pass, mem_ce, mem_wre, mem_reset = 0; mem_oce = 1.
  - mem_ad, mem_din, err_* , err_cnt = 0.
  - A reset mid-run aborts immediately with no done pulse.
- All mem_* outputs are registered.
- States: IDLE, FILL, MARCH, VERIFY, DRAIN.
- IDLE: start=1 sampled at edge E0 clears err_*, err_cnt and pass, sets busy, and enters FILL with address 0. start in any other state is ignored.
- Cycle k is the cycle ending at edge Ek. Every state except DRAIN issues one access per cycle (mem_ce=1) at ascending addresses 0..2^ADDR_W-1, then wraps to 0 and advances state.
  - FILL, cycles 1-16: wre=1, din=pat(a).
  - MARCH, cycles 17-32: wre=1, din=~pat(a). Old data returned on dout is checked against pat(a).
  - VERIFY, cycles 33-48: wre=0. dout is checked against ~pat(a).
  - DRAIN, cycle 49: mem_ce=0, last compare only.
- Check pipeline:
  - Access issued in cycle k is captured by the RAM at Ek. mem_dout is sampled and compared at Ek+1.
  - A one-stage register carries check-valid, expected value, address and phase.
  - FILL accesses are never checked.
- On mismatch: err_cnt increments (saturating at 255). If it is the first mismatch, err_addr/exp/got/phase are latched.
- At E49: done=1 for one cycle, busy=0, pass=(err_cnt==0 including the E49 compare), return to IDLE. Run latency is 49 edges after E0.
- start held high continuously starts a new run the cycle after done; the previous result stays visible during done.

Test Plan:
- Reset, then no start -> busy=0, mem_ce=0, mem_oce=1, all err outputs 0 for 20 cycles.
- Fault-free RAM model, start one cycle -> done pulse exactly 49 edges after the sampling edge, pass=1, err_cnt=0. Final RAM contents: addr 3 = ~(A5^03)=8'h59.
- Model with bit 0 of addr 5 stuck at 1 -> pass=0, err_cnt=1, err_addr=5, err_phase=1, err_exp=8'hA0, err_got=8'hA1. (VERIFY expects 8'h5F and reads 8'h5F, so it does not count.)
- Model with all cells bit 7 stuck at 0 -> err_cnt=16, first error addr 0, phase 1, exp 8'hA5, got 8'h25.
- reset_n pulsed low at cycle 25 -> all outputs return to reset values asynchronously, no done. A fresh start then passes normally.
- start asserted while busy at cycle 10 -> ignored, single done at edge 49. start held high -> back-to-back runs, done every 50 cycles.
